imem_loader: RTL
================

# imem_loader

Boot-time writer for the single-cycle core's instruction memory. Accepts a byte stream over a valid/ready handshake, packs each group of four bytes little-endian into a 32-bit instruction word, and writes it to consecutive word addresses through the instruction memory's write port. The core is held in reset by this block until the programmed number of words has been written.

## Interface

**Parameters**
- `DATA_WIDTH`, default 32: instruction word width. Fixed at 4 bytes.
- `ADDRESS_WIDTH`, default 8: byte address width of instruction memory. Matches the 8-bit PC slice.

**Ports**
- `clk`, in, 1: clock.
- `rst`, in, 1: asynchronous, active-high reset.
- `start`, in, 1: begin a load. Sampled only in IDLE or DONE.
- `word_count`, in, ADDRESS_WIDTH-1: number of words to load, 0..2^(ADDRESS_WIDTH-2). Latched when `start` is accepted.
- `byte_valid`, in, 1: `byte_data` is valid.
- `byte_data`, in, 8: stream byte.
- `byte_ready`, out, 1: the block can accept a byte this cycle.
- `mem_we`, out, 1: instruction memory write enable.
- `mem_addr`, out, ADDRESS_WIDTH: byte address. Always word-aligned (low two bits 0).
- `mem_wd`, out, DATA_WIDTH: write data.
- `cpu_rst`, out, 1: reset for the core. Drives the core's `rst`.
- `busy`, out, 1: asserted in RECV and WRITE.
- `done`, out, 1: asserted in DONE.

## Operation

**States:** IDLE, RECV, WRITE, DONE.

**IDLE** (reset state)
- `cpu_rst`=1; `byte_ready`, `mem_we`, `busy`, `done` all 0.
- On `start`: latch `word_count` and clear the word index and byte index.
- Next state is RECV if `word_count` is nonzero, otherwise DONE.

**RECV**
- `byte_ready`=1.
- A byte is accepted only when `byte_valid` and `byte_ready` are both high.
- Byte k of the current word (k=0..3) is stored at bits [8k+7:8k].
- On acceptance of byte 3, go to WRITE. `byte_valid` low stalls without changing state.

**WRITE** (exactly one cycle)
- `byte_ready`=0, `mem_we`=1.
- `mem_addr` = word_index × 4 (truncated to ADDRESS_WIDTH); `mem_wd` = assembled word.
- Then increment word_index. Next state is DONE if word_index+1 equals the latched count, otherwise RECV.

**DONE**
- `cpu_rst`=0, `done`=1.
- `start` returns to IDLE behaviour in the same cycle it is sampled: `cpu_rst` reasserts on the next cycle and a new load begins.

**Rules**
- `start` is ignored while `busy`.
- `mem_addr` and `mem_wd` are don't-care when `mem_we`=0, but must be held stable (no glitch requirement).
- A full-memory load (count = 2^(ADDRESS_WIDTH-2)) ends at the last word. It never wraps to write address 0.
- Asynchronous `rst` mid-load:
  - Go to IDLE immediately and drop `mem_we`.
  - Discard the partial word.
  - `cpu_rst`=1.
  - No write is issued for a partial word.

## Timing

- All outputs are registered or decoded from state only, with no combinational path from inputs to outputs.
- Reset values: `cpu_rst`=1; all other outputs 0.
- `start` in cycle t gives RECV with `byte_ready`=1 in cycle t+1.
- With `byte_valid` held high, each word takes 5 cycles (4 RECV + 1 WRITE). An N-word load asserts `done` at cycle t+1+5N.
- `cpu_rst` falls in the same cycle `done` rises.

## Structure

- Package `imem_loader_pkg` holds:
  - the state enum `loader_state_t`;
  - `BYTES_PER_WORD`=4;
  - the reset value of `cpu_rst`.
- One sub-module, `word_assembler`, is natural. It contains:
  - the byte index counter;
  - the shift/packing register;
  - the `word_full` flag.
- FSM and word counter stay in `imem_loader`.

## Test plan

1. **Reset:** assert `rst` for 2 cycles. Required: `cpu_rst`=1, `byte_ready`=`mem_we`=`busy`=`done`=0; `start`=0 keeps it in IDLE.
2. **Two-word load:** `word_count`=2, continuous bytes 13 05 F0 0F 93 05 10 00. Required:
   - write addr 0x00 data 0x0FF00513;
   - write addr 0x04 data 0x00100593;
   - `done`=1 and `cpu_rst`=0 at cycle start+11.
3. **Backpressure:** same stream with `byte_valid` low on alternate cycles. Required: identical writes, and no byte consumed while `byte_valid`=0.
4. **Empty load:** `word_count`=0. Required: `done` the cycle after `start`, with no `mem_we` pulse.
5. **Reset mid-load:** assert `rst` after 2 bytes. Required:
   - no write;
   - `cpu_rst`=1;
   - a new `start` with 1 word writes addr 0x00 with the new bytes only.
6. **Full load and ignored start:** `word_count`=64 with `start` pulsed mid-load. Required:
   - the mid-load `start` is ignored;
   - the last write is to addr 0xFC;
   - exactly 64 `mem_we` pulses occur.

Source files
------------

// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
package imem_loader_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RECV,
        ST_WRITE,
        ST_DONE
    } loader_state_t;

    localparam int   BYTES_PER_WORD = 4;
    localparam logic CPU_RST_RESET  = 1'b1;

endpackage

// File: rtl/word_assembler.sv
// Packs accepted stream bytes little-endian into one instruction word.
module word_assembler
    import imem_loader_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear_i,
    input  logic                  accept_i,
    input  logic [7:0]            byte_i,
    output logic [DATA_WIDTH-1:0] word_o,
    output logic                  word_full_o
);

    localparam int BW = $clog2(BYTES_PER_WORD);

    logic [BW-1:0]         idx_q, idx_d;
    logic [DATA_WIDTH-1:0] word_q, word_d;

    always_comb begin
        idx_d  = idx_q;
        word_d = word_q;
        if (clear_i) begin
            idx_d = '0;
        end else if (accept_i) begin
            word_d[int'(idx_q)*8 +: 8] = byte_i;
            idx_d = idx_q + BW'(1);
        end
    end

    // The last byte completes the word; the index wraps back to 0 for the next one.
    assign word_full_o = accept_i && (idx_q == BW'(BYTES_PER_WORD - 1));
    assign word_o      = word_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_q  <= '0;
            word_q <= '0;
        end else begin
            idx_q  <= idx_d;
            word_q <= word_d;
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Boot-time instruction memory writer: streams bytes into words, writes them
// to consecutive word addresses and holds the core in reset until finished.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [ADDRESS_WIDTH-2:0] word_count,
    input  logic                     byte_valid,
    input  logic [7:0]               byte_data,
    output logic                     byte_ready,
    output logic                     mem_we,
    output logic [ADDRESS_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0]    mem_wd,
    output logic                     cpu_rst,
    output logic                     busy,
    output logic                     done
);

    localparam int CW = ADDRESS_WIDTH - 1;
    localparam int IW = ADDRESS_WIDTH - 2;

    loader_state_t state_q, state_d;
    logic [CW-1:0] count_q, count_d;
    logic [CW-1:0] widx_q, widx_d;
    logic          clear;
    logic          accept;
    logic          word_full;

    assign accept = byte_valid && byte_ready;

    word_assembler #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_asm (
        .clk        (clk),
        .rst        (rst),
        .clear_i    (clear),
        .accept_i   (accept),
        .byte_i     (byte_data),
        .word_o     (mem_wd),
        .word_full_o(word_full)
    );

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        widx_d  = widx_q;
        clear   = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    count_d = word_count;
                    widx_d  = '0;
                    clear   = 1'b1;
                    state_d = (word_count == '0) ? ST_DONE : ST_RECV;
                end
            end
            ST_RECV: begin
                if (word_full) state_d = ST_WRITE;
            end
            ST_WRITE: begin
                // Index is wide enough to hold the full count, so a full load never wraps.
                widx_d  = widx_q + CW'(1);
                state_d = (widx_q + CW'(1) == count_q) ? ST_DONE : ST_RECV;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        byte_ready = (state_q == ST_RECV);
        mem_we     = (state_q == ST_WRITE);
        busy       = (state_q == ST_RECV) || (state_q == ST_WRITE);
        done       = (state_q == ST_DONE);
        cpu_rst    = (state_q == ST_DONE) ? ~CPU_RST_RESET : CPU_RST_RESET;
        mem_addr   = {widx_q[IW-1:0], 2'b00};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            count_q <= '0;
            widx_q  <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            widx_q  <= widx_d;
        end
    end

endmodule
